// File: rtl/cfg_loader_if.sv
// Word stream, serial chain and readback signals of the configuration loader.
// The master side feeds words and owns the chain tail. The slave side is the loader.
interface cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              config_en;
  logic              config_data_out;
  logic              config_data_in;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output word_data, word_valid, config_data_in,
    input  word_ready, config_en, config_data_out, rb_data, rb_valid
  );

  modport slave (
    input  word_data, word_valid, config_data_in,
    output word_ready, config_en, config_data_out, rb_data, rb_valid
  );
endinterface

// File: rtl/cfg_loader.sv
// Serialises configuration words MSB-first into a CHAIN_LEN-bit shift chain.
// Bits returning from the chain tail are reassembled into readback words.
module cfg_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  cfg_loader_if.slave    bus,
  output logic           busy,
  output logic           done,
  output logic           aborted
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int HW    = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} stateType;

  stateType          state, stateNext;
  logic [CNT_W-1:0]  shiftCnt, shiftCntNext;
  logic [HW-1:0]     bitsLeft, bitsLeftNext;
  logic [WORD_W-1:0] holdReg, holdRegNext;
  logic              enReg, enNext;
  logic [WORD_W-1:0] rbShift, rbShiftNext;
  logic [HW-1:0]     rbCnt, rbCntNext;
  logic [WORD_W-1:0] rbData, rbDataNext;
  logic              rbValid, rbValidNext;
  logic              abortedReg, abortedNext;

  logic [CNT_W-1:0]  remain;
  logic [HW-1:0]     loadBits;
  logic              readyInt;
  logic              accept;
  logic              lastShift;
  logic [WORD_W-1:0] sampled;

  // Bits still owed to the chain beyond the word currently held.
  assign remain    = CNT_W'(CHAIN_LEN) - shiftCnt - CNT_W'(bitsLeft);
  assign loadBits  = (32'(remain) >= 32'(WORD_W)) ? HW'(WORD_W) : HW'(remain);
  assign readyInt  = (state == LOAD) && (bitsLeft <= HW'(1)) && (remain != '0);
  assign accept    = readyInt && bus.word_valid;
  assign lastShift = enReg && (shiftCnt == CNT_W'(CHAIN_LEN - 1));
  assign sampled   = (rbShift << 1) | WORD_W'(bus.config_data_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shiftCnt   <= '0;
      bitsLeft   <= '0;
      holdReg    <= '0;
      enReg      <= 1'b0;
      rbShift    <= '0;
      rbCnt      <= '0;
      rbData     <= '0;
      rbValid    <= 1'b0;
      abortedReg <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftCnt   <= shiftCntNext;
      bitsLeft   <= bitsLeftNext;
      holdReg    <= holdRegNext;
      enReg      <= enNext;
      rbShift    <= rbShiftNext;
      rbCnt      <= rbCntNext;
      rbData     <= rbDataNext;
      rbValid    <= rbValidNext;
      abortedReg <= abortedNext;
    end
  end

  always_comb begin
    stateNext    = state;
    shiftCntNext = shiftCnt;
    bitsLeftNext = bitsLeft;
    holdRegNext  = holdReg;
    enNext       = 1'b0;
    rbShiftNext  = rbShift;
    rbCntNext    = rbCnt;
    rbDataNext   = rbData;
    rbValidNext  = 1'b0;
    abortedNext  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext    = LOAD;
          shiftCntNext = '0;
          bitsLeftNext = '0;
          rbShiftNext  = '0;
          rbCntNext    = '0;
        end
      end

      LOAD: begin
        if (abort) begin
          stateNext    = IDLE;
          bitsLeftNext = '0;
          holdRegNext  = '0;
          rbShiftNext  = '0;
          rbCntNext    = '0;
          abortedNext  = 1'b1;
        end else begin
          if (enReg) begin
            shiftCntNext = shiftCnt + CNT_W'(1);
            holdRegNext  = holdReg << 1;
            bitsLeftNext = bitsLeft - HW'(1);
            // A full word or the chain's final bit flushes the assembler, left-aligned.
            if (lastShift || (rbCnt == HW'(WORD_W - 1))) begin
              rbDataNext  = sampled << (HW'(WORD_W - 1) - rbCnt);
              rbValidNext = 1'b1;
              rbShiftNext = '0;
              rbCntNext   = '0;
            end else begin
              rbShiftNext = sampled;
              rbCntNext   = rbCnt + HW'(1);
            end
          end
          if (accept) begin
            holdRegNext  = bus.word_data;
            bitsLeftNext = loadBits;
          end
          if (lastShift) begin
            stateNext = DONE;
          end
          enNext = (bitsLeftNext != '0);
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign bus.word_ready      = readyInt;
  assign bus.config_en       = enReg;
  assign bus.config_data_out = holdReg[WORD_W-1];
  assign bus.rb_data         = rbData;
  assign bus.rb_valid        = rbValid;
  assign busy                = (state != IDLE);
  assign done                = (state == DONE);
  assign aborted             = abortedReg;

  // The shift count saturates at the chain length and shifting only happens while loading.
  assert property (@(posedge clk) disable iff (rst) shiftCnt <= CNT_W'(CHAIN_LEN));
  assert property (@(posedge clk) disable iff (rst) enReg |-> (state == LOAD));

endmodule

// File: tb/tb_cfg_loader.sv
// Testbench for cfg_loader: table-driven loads against a chain model, with a scoreboard
// for serial and readback data, plus abort and reset sequences.
module tb_cfg_loader;
  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, aborted;

  cfg_loader_if #(.WORD_W(WORD_W)) busIf ();

  cfg_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(busIf),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Target chain model: head at bit 0, tail at bit CHAIN_LEN-1.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] preloadVal = '0;
  logic doPreload = 1'b0;
  always @(posedge clk) begin
    if (doPreload) chain <= preloadVal;
    else if (busIf.config_en) chain <= {chain[CHAIN_LEN-2:0], busIf.config_data_out};
  end
  assign busIf.config_data_in = chain[CHAIN_LEN-1];

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          stall;
    logic [19:0] preload;
    logic [19:0] expChain;
    logic [7:0]  r0, r1, r2;
    int          expBubbles;
    bit          midStart;
    bit          startWithAbort;
  } vecT;

  vecT vecs[4];
  int checks = 0;
  int errors = 0;
  logic bitQ[$];
  logic [7:0] rbQ[$];
  int pushed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!busIf.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wordReadySeen", 32'(busIf.word_ready), 32'd1);
  endtask

  task automatic sendWord(input logic [7:0] w);
    busIf.word_data  = w;
    busIf.word_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (pushed < CHAIN_LEN) begin
        bitQ.push_back(w[i]);
        pushed++;
      end
    end
    waitReady();
    @(posedge clk);
    #1;
  endtask

  task automatic preloadChain(input logic [19:0] val);
    preloadVal = val;
    doPreload  = 1'b1;
    @(posedge clk);
    #1;
    doPreload  = 1'b0;
  endtask

  task automatic applyStimulus(input vecT v);
    preloadChain(v.preload);
    bitQ.delete();
    rbQ.delete();
    pushed = 0;
    rbQ.push_back(v.r0);
    rbQ.push_back(v.r1);
    rbQ.push_back(v.r2);
    busIf.word_data  = v.w0;
    busIf.word_valid = 1'b1;
    start = 1'b1;
    abort = v.startWithAbort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    fork
      begin : feeder
        sendWord(v.w0);
        if (v.midStart) begin
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        if (v.stall > 0) begin
          busIf.word_valid = 1'b0;
          repeat (v.stall) begin
            waitReady();
            @(posedge clk);
            #1;
          end
        end
        sendWord(v.w1);
        sendWord(v.w2);
        busIf.word_valid = 1'b0;
      end
      begin : monitor
        int enCount = 0;
        int bubbles = 0;
        bit lastEn = 1'b0;
        bit doneSeen = 1'b0;
        logic expBit;
        logic [7:0] expRb;
        for (int cyc = 0; cyc < 300 && !doneSeen; cyc++) begin
          @(negedge clk);
          if (busIf.rb_valid) begin
            if (rbQ.size() > 0) begin
              expRb = rbQ.pop_front();
              checkOutput("rbData", 32'(busIf.rb_data), 32'(expRb));
              if (rbQ.size() == 0) checkOutput("lastRbWithDone", 32'(done), 32'd1);
            end else begin
              checks++;
              errors++;
              $display("[TB] FAIL rbExtra: got 0x%0h, expected no strobe", busIf.rb_data);
            end
          end
          if (busIf.config_en) begin
            if (bitQ.size() > 0) begin
              expBit = bitQ.pop_front();
              checkOutput("serialBit", 32'(busIf.config_data_out), 32'(expBit));
            end else begin
              checks++;
              errors++;
              $display("[TB] FAIL serialExtra: got shift %0d, expected none", enCount + 1);
            end
            enCount++;
          end else if (busy && !done && enCount > 0) begin
            bubbles++;
          end
          if (done) begin
            checkOutput("doneAfterLastEn", 32'({lastEn, busIf.config_en}), 32'b10);
            doneSeen = 1'b1;
          end
          lastEn = busIf.config_en;
        end
        checkOutput("doneSeen", 32'(doneSeen), 32'd1);
        checkOutput("enCount", 32'(enCount), 32'(CHAIN_LEN));
        checkOutput("bubbles", 32'(bubbles), 32'(v.expBubbles));
      end
    join
    checkOutput("chainContents", 32'(chain), 32'(v.expChain));
    checkOutput("bitQueueEmpty", 32'(bitQ.size()), 32'd0);
    checkOutput("rbQueueEmpty", 32'(rbQ.size()), 32'd0);
    @(negedge clk);
    checkOutput("idleAfterDone", 32'({busy, done}), 32'd0);
  endtask

  function automatic logic [14:0] allOutputs();
    return {busIf.word_ready, busIf.config_en, busIf.config_data_out, busIf.rb_data,
            busIf.rb_valid, busy, done, aborted};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawPulse;
    busIf.word_data  = '0;
    busIf.word_valid = 1'b0;

    vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 0, 20'hABCDE, 20'hA53CF, 8'hAB, 8'hCD, 8'hE0, 0, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 3, 20'hABCDE, 20'hA53CF, 8'hAB, 8'hCD, 8'hE0, 3, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 1, 20'hFFFFF, 20'h12345, 8'hFF, 8'hFF, 8'hF0, 1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 8'h9C, 0, 20'h12345, 20'hFF009, 8'h12, 8'h34, 8'h50, 0, 1'b0, 1'b1};

    // Power-on reset asserted mid-cycle, before any clock edge.
    #2 rst = 1'b1;
    #1 checkOutput("resetOutputs", 32'(allOutputs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Abort after ten shifts.
    $display("[TB] abort sequence");
    preloadChain(20'hABCDE);
    pushed = 0;
    busIf.word_data  = 8'hA5;
    busIf.word_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sendWord(8'hA5);
    sendWord(8'h3C);
    busIf.word_valid = 1'b0;
    @(negedge clk);
    checkOutput("abortShift9En", 32'(busIf.config_en), 32'd1);
    checkOutput("abortRbValid", 32'(busIf.rb_valid), 32'd1);
    checkOutput("abortRbData", 32'(busIf.rb_data), 32'hAB);
    @(negedge clk);
    checkOutput("abortShift10En", 32'(busIf.config_en), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abortEnRbBusyDone", 32'({busIf.config_en, busIf.rb_valid, busy, done}), 32'd0);
    checkOutput("abortedPulse", 32'(aborted), 32'd1);
    checkOutput("abortChain", 32'(chain), 32'h37A94);
    @(negedge clk);
    checkOutput("abortedOneCycle", 32'({aborted, done}), 32'd0);
    bitQ.delete();

    $display("[TB] fresh load after abort");
    applyStimulus(vecs[0]);

    // Reset asserted in the middle of a load.
    $display("[TB] mid-load reset");
    preloadChain(20'hABCDE);
    pushed = 0;
    busIf.word_data  = 8'hA5;
    busIf.word_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sendWord(8'hA5);
    sendWord(8'h3C);
    @(negedge clk);
    checkOutput("enBeforeReset", 32'(busIf.config_en), 32'd1);
    #2 rst = 1'b1;
    #1 checkOutput("midLoadResetOutputs", 32'(allOutputs()), 32'd0);
    busIf.word_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sawPulse = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sawPulse = sawPulse | busy | done | aborted | busIf.config_en;
    end
    checkOutput("quietAfterReset", 32'(sawPulse), 32'd0);
    bitQ.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
